// File: rtl/code_sender_pkg.sv
// Shared constants for the code sender: default parameters, bit order,
// FSM state encodings and a helper to size the shared timer.
package code_sender_pkg;

  localparam int DEF_CODE_LEN     = 4;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int DEF_RESP_TIMEOUT = 8;

  // Code bits leave the shift register starting from the most significant bit.
  localparam bit MSB_FIRST = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t SEND      = 3'd1;
  localparam state_t GAP       = 3'd2;
  localparam state_t WAIT_RESP = 3'd3;
  localparam state_t DONE      = 3'd4;

  // The timer serves both the gap count and the response timeout, so it must
  // hold the larger of the two.
  function automatic int timerWidth(input int gap, input int resp);
    int maxVal;
    maxVal = (gap > resp) ? gap : resp;
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/code_sender_if.sv
// Bundle between the controller, the code sender and the lock.
// The slave modport is the code sender's view; master is the environment's.
interface code_sender_if
  import code_sender_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN
) ();

  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                key_in;
  logic                enter;
  logic                locked_in;
  logic                unlocked_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic                fail;
  logic                timeout;

  modport slave (
    input  start, code, locked_in, unlocked_in,
    output key_in, enter, busy, done, pass, fail, timeout
  );

  modport master (
    output start, code, locked_in, unlocked_in,
    input  key_in, enter, busy, done, pass, fail, timeout
  );

endinterface

// File: rtl/code_sender_gap_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load a new count or step down toward zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/code_sender.sv
// Drives a stored code into the lock as key_in/enter strobes and reports
// whether the lock opened, reported an error, or never answered.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int CODE_LEN     = DEF_CODE_LEN,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input logic          clk,
  input logic          reset_n,
  code_sender_if.slave bus
);

  localparam int TW      = timerWidth(GAP_CYCLES, RESP_TIMEOUT);
  localparam int CW      = $clog2(CODE_LEN + 1);
  localparam int OUT_IDX = MSB_FIRST ? CODE_LEN - 1 : 0;

  localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] RESP_LOAD = TW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] BITS_INIT = CW'(CODE_LEN);

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]       bits_q, bits_d;
  logic                key_q, key_d;
  logic                enter_q, enter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;

  logic                timer_load;
  logic [TW-1:0]       timer_val;
  logic                timer_dec;
  logic                timer_zero;

  gap_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .dec_i     (timer_dec),
    .zero_o    (timer_zero)
  );

  // Next-state logic; outputs are derived from the state being entered so
  // that every output can be registered without adding a cycle of latency.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    key_d      = 1'b0;
    enter_d    = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    timer_load = 1'b0;
    timer_val  = '0;
    timer_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.code;
          bits_d    = BITS_INIT;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bits_d  = bits_q - CW'(1);
        if (bits_q != CW'(1)) begin
          if (GAP_CYCLES > 0) begin
            timer_load = 1'b1;
            timer_val  = GAP_LOAD;
            state_d    = GAP;
          end else begin
            state_d = SEND;
          end
        end else begin
          timer_load = 1'b1;
          timer_val  = RESP_LOAD;
          state_d    = WAIT_RESP;
        end
      end
      GAP: begin
        if (bus.locked_in) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (timer_zero) begin
          state_d = SEND;
        end else begin
          timer_dec = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (bus.locked_in) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (bus.unlocked_in) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (timer_zero) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == SEND) begin
      enter_d = 1'b1;
      key_d   = shift_d[OUT_IDX];
    end
  end

  assign busy_d = (state_d != IDLE);
  assign done_d = (state_d == DONE);

  // State, shift register and registered outputs; reset discards any attempt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bits_q    <= '0;
      key_q     <= 1'b0;
      enter_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      key_q     <= key_d;
      enter_q   <= enter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.key_in  = key_q;
  assign bus.enter   = enter_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: a GAP_CYCLES=2 instance and a
// GAP_CYCLES=0 instance share one behavioural lock whose code is 4'b1011.
module tb_code_sender;

  logic clk;
  logic reset_n;

  code_sender_if #(.CODE_LEN(4)) bus0 ();
  code_sender_if #(.CODE_LEN(4)) bus1 ();

  code_sender #(.CODE_LEN(4), .GAP_CYCLES(2), .RESP_TIMEOUT(8)) dutGap2 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus0)
  );

  code_sender #(.CODE_LEN(4), .GAP_CYCLES(0), .RESP_TIMEOUT(8)) dutGap0 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       sel;
  logic       startR;
  logic [3:0] codeR;
  int         lockMode;
  logic       bothNow;
  logic       lockClear;

  assign bus0.start = startR & ~sel;
  assign bus1.start = startR & sel;
  assign bus0.code  = codeR;
  assign bus1.code  = codeR;

  logic selEnter, selKey, selBusy, selDone, selPass, selFail, selTimeout;
  assign selEnter   = sel ? bus1.enter   : bus0.enter;
  assign selKey     = sel ? bus1.key_in  : bus0.key_in;
  assign selBusy    = sel ? bus1.busy    : bus0.busy;
  assign selDone    = sel ? bus1.done    : bus0.done;
  assign selPass    = sel ? bus1.pass    : bus0.pass;
  assign selFail    = sel ? bus1.fail    : bus0.fail;
  assign selTimeout = sel ? bus1.timeout : bus0.timeout;

  // Lock model: checks each entered bit against its code on the enter edge;
  // a wrong bit latches locked, the last correct bit latches unlocked.
  logic [3:0] lockCode;
  logic       lkLocked;
  logic       lkUnlocked;
  int         lkCnt;

  always @(posedge clk) begin
    if (lockClear) begin
      lkLocked   <= 1'b0;
      lkUnlocked <= 1'b0;
      lkCnt      <= 0;
    end else if (selEnter && !lkLocked && !lkUnlocked) begin
      if (selKey != lockCode[3 - lkCnt]) begin
        lkLocked <= 1'b1;
      end else if (lkCnt == 3) begin
        lkUnlocked <= 1'b1;
      end
      lkCnt <= lkCnt + 1;
    end
  end

  logic lockedLine, unlockedLine;
  assign lockedLine   = (lockMode == 0) ? lkLocked   : (lockMode == 2) ? bothNow : 1'b0;
  assign unlockedLine = (lockMode == 0) ? lkUnlocked : (lockMode == 2) ? bothNow : 1'b0;
  assign bus0.locked_in   = lockedLine;
  assign bus0.unlocked_in = unlockedLine;
  assign bus1.locked_in   = lockedLine;
  assign bus1.unlocked_in = unlockedLine;

  typedef struct {
    logic        sel;
    logic [3:0]  code;
    int          mode;
    int          bothFrom;
    int          expDone;
    logic [31:0] expEnter;
    logic [31:0] expKey;
    logic        expPass;
    logic        expFail;
    logic        expTimeout;
  } vec_t;

  vec_t vecs[9];

  int testsRun;
  int testsFailed;

  logic [31:0] enterMask;
  logic [31:0] keyMask;
  int          doneCycle;
  int          doneCount;
  int          busyCount;
  int          bothErr;
  logic        passAtDone, failAtDone, toAtDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Starts one attempt and records per-cycle activity; cycle 1 is the first
  // cycle after the edge that samples start.
  task automatic applyStimulus(input logic s, input logic [3:0] c, input int m,
                               input int bf, input int extraAt);
    sel      = s;
    lockMode = m;
    bothNow  = 1'b0;
    @(negedge clk);
    lockClear = 1'b1;
    @(negedge clk);
    lockClear = 1'b0;
    codeR     = c;
    startR    = 1'b1;
    @(posedge clk);
    #1;
    startR     = 1'b0;
    enterMask  = '0;
    keyMask    = '0;
    doneCycle  = 0;
    doneCount  = 0;
    busyCount  = 0;
    bothErr    = 0;
    passAtDone = 1'b0;
    failAtDone = 1'b0;
    toAtDone   = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bf > 0 && cyc >= bf) bothNow = 1'b1;
      startR = (cyc == extraAt);
      if (selEnter) enterMask[cyc] = 1'b1;
      if (selKey)   keyMask[cyc]   = 1'b1;
      if (selBusy)  busyCount++;
      if (selPass && selFail) bothErr++;
      if (selDone) begin
        doneCount++;
        if (doneCycle == 0) begin
          doneCycle  = cyc;
          passAtDone = selPass;
          failAtDone = selFail;
          toAtDone   = selTimeout;
        end
      end
      if (doneCycle != 0 && cyc >= doneCycle + 2) break;
      @(posedge clk);
      #1;
    end
    startR  = 1'b0;
    bothNow = 1'b0;
  endtask

  task automatic checkAttempt(input string tag, input vec_t v);
    checkOutput({tag, " enterCycles"}, enterMask, v.expEnter);
    checkOutput({tag, " keyBits"}, keyMask, v.expKey);
    checkOutput({tag, " doneCycle"}, doneCycle, v.expDone);
    checkOutput({tag, " donePulses"}, doneCount, 1);
    checkOutput({tag, " busyCycles"}, busyCount, v.expDone);
    checkOutput({tag, " pass"}, passAtDone, v.expPass);
    checkOutput({tag, " fail"}, failAtDone, v.expFail);
    checkOutput({tag, " timeout"}, toAtDone, v.expTimeout);
    checkOutput({tag, " passAndFail"}, bothErr, 0);
  endtask

  task automatic runVector(input int idx, input vec_t v);
    applyStimulus(v.sel, v.code, v.mode, v.bothFrom, 0);
    checkAttempt($sformatf("v%0d", idx), v);
  endtask

  initial begin
    int   waitCnt;
    logic gotDone;
    logic doneSeen;

    testsRun    = 0;
    testsFailed = 0;
    lockCode    = 4'b1011;
    reset_n     = 1'b0;
    sel         = 1'b0;
    startR      = 1'b0;
    codeR       = 4'b0000;
    lockMode    = 0;
    bothNow     = 1'b0;
    lockClear   = 1'b1;

    // sel, code, mode, bothFrom, done, enter cycles, key cycles, pass, fail, timeout
    vecs[0] = '{1'b0, 4'b1011, 0, 0, 12, 32'h492, 32'h482, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b1001, 0, 0,  9, 32'h092, 32'h002, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'b1011, 1, 0, 19, 32'h492, 32'h482, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'b1011, 2, 11, 12, 32'h492, 32'h482, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'b0011, 0, 0,  3, 32'h002, 32'h000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'b1111, 0, 0,  6, 32'h012, 32'h012, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'b1011, 0, 0,  6, 32'h01E, 32'h01A, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'b1011, 1, 0, 13, 32'h01E, 32'h01A, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 4'b0111, 0, 0,  6, 32'h01E, 32'h01C, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset enter", bus0.enter, 0);
    checkOutput("reset key_in", bus0.key_in, 0);
    checkOutput("reset busy", bus0.busy, 0);
    checkOutput("reset done", bus0.done, 0);
    checkOutput("reset pass", bus0.pass, 0);
    checkOutput("reset fail", bus0.fail, 0);
    checkOutput("reset timeout", bus0.timeout, 0);
    checkOutput("reset busy gap0", bus1.busy, 0);
    @(negedge clk);
    reset_n   = 1'b1;
    lockClear = 1'b0;

    for (int i = 0; i < 9; i++) begin
      runVector(i, vecs[i]);
    end

    // Second start while busy must be ignored; pass then holds until the next start.
    applyStimulus(1'b0, 4'b1011, 0, 0, 5);
    checkAttempt("ignoreStart", vecs[0]);
    checkOutput("passHeldIdle", bus0.pass, 1);
    checkOutput("idleAfterDone busy", bus0.busy, 0);
    @(negedge clk);
    checkOutput("passHeldLater", bus0.pass, 1);
    lockClear = 1'b1;
    @(negedge clk);
    lockClear = 1'b0;
    codeR     = 4'b1011;
    startR    = 1'b1;
    @(posedge clk);
    #1;
    startR = 1'b0;
    checkOutput("passClearedOnStart", bus0.pass, 0);
    checkOutput("busyOnStart", bus0.busy, 1);
    gotDone = 1'b0;
    waitCnt = 0;
    while (!gotDone && waitCnt < 30) begin
      @(posedge clk);
      #1;
      waitCnt++;
      if (bus0.done) gotDone = 1'b1;
    end
    checkOutput("restartDone", gotDone, 1);
    checkOutput("restartPass", bus0.pass, 1);

    // Reset while a bit is on the wire: enter drops at once and no done follows.
    sel      = 1'b0;
    lockMode = 0;
    @(negedge clk);
    lockClear = 1'b1;
    @(negedge clk);
    lockClear = 1'b0;
    codeR     = 4'b1011;
    startR    = 1'b1;
    @(posedge clk);
    #1;
    startR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midReset enterBefore", bus0.enter, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midReset enter", bus0.enter, 0);
    checkOutput("midReset busy", bus0.busy, 0);
    checkOutput("midReset pass", bus0.pass, 0);
    doneSeen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus0.done) doneSeen = 1'b1;
    end
    checkOutput("midReset noDone", doneSeen, 0);
    @(negedge clk);
    reset_n = 1'b1;
    runVector(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
